tl_ul_ram_slave: RTL and testbench

TileLink-UL responder (slave end) fronting a single-ported, byte-maskable word RAM. It accepts Get, PutFullData and PutPartialData on channel A and returns AccessAckData or AccessAck on channel D through a one-entry response register. It sits behind the tilelink interface's slave_ul modport as the memory endpoint for any master_ul agent, such as the core's fetch or data ports.

---
 rtl/tl_ul_ram_slave_pkg.sv | 31 +++
 rtl/tilelink.sv | 38 +++
 rtl/tl_ram_array.sv | 27 ++
 rtl/tl_ul_ram_slave.sv | 108 ++++++++++
 tb/tb_tl_ul_ram_slave.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/tl_ul_ram_slave_pkg.sv
// Shared TileLink-UL opcode encodings and the contiguous byte-mask helper
// used by the RAM responder.
package tl_ul_ram_slave_pkg;

  localparam int TL_MAX_W = 64;

  typedef enum logic [2:0] {
    TL_PUT_FULL    = 3'd0,
    TL_PUT_PARTIAL = 3'd1,
    TL_GET         = 3'd4
  } tl_a_opcode_t;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_t;

  // Byte lanes covered by a 2^size access starting at lane addr_lo; callers slice to W.
  function automatic logic [TL_MAX_W-1:0] tl_size_mask(input logic [5:0] size,
                                                        input logic [5:0] addr_lo);
    logic [TL_MAX_W-1:0] m;
    m = '0;
    if (size <= 6'd6) begin
      for (int b = 0; b < TL_MAX_W; b++) begin
        if (b >= int'(addr_lo) && b < int'(addr_lo) + (1 << size)) m[b] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/tilelink.sv
// TileLink-UL channel A/D bundle with master and slave views.
interface tilelink #(
  parameter int w = 4,
  parameter int a = 32,
  parameter int z = 4,
  parameter int o = 1,
  parameter int i = 1
);
  logic           a_valid;
  logic           a_ready;
  logic [2:0]     a_opcode;
  logic [2:0]     a_param;
  logic [z-1:0]   a_size;
  logic [o-1:0]   a_source;
  logic [a-1:0]   a_address;
  logic [w-1:0]   a_mask;
  logic [8*w-1:0] a_data;

  logic           d_valid;
  logic           d_ready;
  logic [2:0]     d_opcode;
  logic [1:0]     d_param;
  logic [z-1:0]   d_size;
  logic [o-1:0]   d_source;
  logic [i-1:0]   d_sink;
  logic [8*w-1:0] d_data;
  logic           d_error;

  modport master_ul (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

  modport slave_ul (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );
endinterface

// File: rtl/tl_ram_array.sv
// Single-ported byte-lane RAM, one lane instance per byte; registered read
// port that holds its value when no read is issued (read-during-write = old data).
module tl_ram_array #(
  parameter int W     = 4,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     re_i,
  input  logic [W-1:0]             we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [8*W-1:0]           wdata_i,
  output logic [8*W-1:0]           rdata_o
);

  for (genvar b = 0; b < W; b++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i[b]) mem_q[addr_i] <= wdata_i[8*b +: 8];
      if (re_i)    rd_q          <= mem_q[addr_i];
    end

    assign rdata_o[8*b +: 8] = rd_q;
  end

endmodule

// File: rtl/tl_ul_ram_slave.sv
// TileLink-UL responder over a byte-maskable word RAM; one-entry D register,
// one-cycle latency, full throughput while d_ready is held high.
module tl_ul_ram_slave
  import tl_ul_ram_slave_pkg::*;
#(
  parameter int           W     = 4,
  parameter int           A     = 32,
  parameter int           Z     = 4,
  parameter int           O     = 1,
  parameter int           I     = 1,
  parameter int           DEPTH = 1024,
  parameter logic [A-1:0] BASE  = '0
) (
  input logic       clk_i,
  input logic       reset_ni,
  tilelink.slave_ul bus
);

  localparam int LW = $clog2(W);
  localparam int AW = $clog2(DEPTH);
  localparam logic [64:0] WIN_END = 65'(BASE) + 65'(DEPTH) * 65'(W);

  if (A < 64 && WIN_END > (65'd1 << A)) begin : g_bad_window
    $error("tl_ul_ram_slave: BASE + DEPTH*W overflows the address width");
  end

  logic               d_valid_q;
  tl_d_opcode_t       d_opcode_q;
  logic [Z-1:0]       d_size_q;
  logic [O-1:0]       d_source_q;
  logic               d_error_q;
  logic               rd_sel_q;

  logic               accept;
  logic               is_get, is_put_full, is_put;
  logic               op_bad, size_bad, misalign, range_bad, mask_bad, err;
  logic [A-1:0]       offset, align_m, word_idx;
  logic [TL_MAX_W-1:0] full_mask;
  logic [W-1:0]       exp_mask;
  logic [W-1:0]       ram_we;
  logic               ram_re;
  logic [8*W-1:0]     ram_rdata;

  assign bus.a_ready = !d_valid_q || bus.d_ready;
  assign accept      = bus.a_valid && bus.a_ready;

  assign is_get      = bus.a_opcode == TL_GET;
  assign is_put_full = bus.a_opcode == TL_PUT_FULL;
  assign is_put      = is_put_full || bus.a_opcode == TL_PUT_PARTIAL;

  // All checks are evaluated in parallel; they collapse into one error bit.
  always_comb begin
    offset    = bus.a_address - BASE;
    word_idx  = offset >> LW;
    op_bad    = !(is_get || is_put);
    size_bad  = 32'(bus.a_size) > LW;
    align_m   = size_bad ? '0 : (A'(1) << bus.a_size) - A'(1);
    misalign  = |(bus.a_address & align_m);
    range_bad = (bus.a_address < BASE) || (word_idx >= A'(DEPTH));
    full_mask = tl_size_mask(6'(bus.a_size), 6'(bus.a_address & A'(W - 1)));
    exp_mask  = full_mask[W-1:0];
    mask_bad  = is_put_full && (bus.a_mask != exp_mask);
    err       = op_bad || size_bad || misalign || range_bad || mask_bad;
  end

  assign ram_we = (accept && !err && is_put) ? bus.a_mask : '0;
  assign ram_re = accept && !err && is_get;

  tl_ram_array #(.W(W), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .re_i    (ram_re),
    .we_i    (ram_we),
    .addr_i  (word_idx[AW-1:0]),
    .wdata_i (bus.a_data),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= TL_ACCESS_ACK;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_error_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else if (accept) begin
      d_valid_q  <= 1'b1;
      d_opcode_q <= is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
      d_size_q   <= bus.a_size;
      d_source_q <= bus.a_source;
      d_error_q  <= err;
      rd_sel_q   <= ram_re;
    end else if (bus.d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  // The RAM read register only moves on a successful Get, so data stays stable under stall.
  assign bus.d_valid  = d_valid_q;
  assign bus.d_opcode = d_opcode_q;
  assign bus.d_param  = '0;
  assign bus.d_size   = d_size_q;
  assign bus.d_source = d_source_q;
  assign bus.d_sink   = '0;
  assign bus.d_data   = rd_sel_q ? ram_rdata : '0;
  assign bus.d_error  = d_error_q;

endmodule

// File: tb/tb_tl_ul_ram_slave.sv
// Randomised plus directed bench for tl_ul_ram_slave against a byte-array model.
module tb_tl_ul_ram_slave;
  localparam int W = 4, A = 32, Z = 4, O = 1, I = 1, DEPTH = 64;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tilelink #(.w(W), .a(A), .z(Z), .o(O), .i(I)) bus ();

  tl_ul_ram_slave #(.W(W), .A(A), .Z(Z), .O(O), .I(I), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  int n_chk = 0, n_fail = 0;

  logic [7:0]  mem_m [DEPTH*W];
  bit          exp_valid;
  logic [2:0]  exp_op;
  logic [3:0]  exp_size;
  logic        exp_src;
  logic [31:0] exp_data;
  bit          exp_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_op = 0; exp_size = 0; exp_src = 0; exp_data = 0; exp_err = 0;
  endtask

  task automatic check_outputs();
    chk("d_valid", bus.d_valid, exp_valid);
    if (exp_valid) begin
      chk("d_opcode", bus.d_opcode, exp_op);
      chk("d_param",  bus.d_param, 0);
      chk("d_size",   bus.d_size, exp_size);
      chk("d_source", bus.d_source, exp_src);
      chk("d_sink",   bus.d_sink, 0);
      chk("d_data",   bus.d_data, exp_data);
      chk("d_error",  bus.d_error, exp_err);
    end
  endtask

  task automatic model_accept(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                              input logic [3:0] mask, input logic [31:0] data, input logic src);
    longint nb, lo, idx;
    logic [3:0] cmask;
    bit err;
    nb = longint'(1) << sz;
    lo = longint'(addr) % W;
    cmask = '0;
    for (int b = 0; b < W; b++) if (b >= lo && b < lo + nb) cmask[b] = 1'b1;
    err = 0;
    if (!(op == 0 || op == 1 || op == 4))                             err = 1;
    else if (nb > W)                                                  err = 1;
    else if (longint'(addr) % nb != 0)                                err = 1;
    else if (addr < BASE || (longint'(addr) - BASE) / W >= DEPTH)     err = 1;
    else if (op == 0 && mask != cmask)                                err = 1;
    idx = err ? 0 : (longint'(addr) - BASE) / W;
    exp_valid = 1;
    exp_op    = (op == 4) ? 3'd1 : 3'd0;
    exp_size  = sz;
    exp_src   = src;
    exp_err   = err;
    exp_data  = 0;
    if (!err && op == 4)
      for (int b = 0; b < W; b++) exp_data[8*b +: 8] = mem_m[idx*W + b];
    if (!err && op != 4)
      for (int b = 0; b < W; b++) if (mask[b]) mem_m[idx*W + b] = data[8*b +: 8];
  endtask

  // One bus cycle: check registered outputs, drive inputs, check a_ready, advance the model.
  task automatic drive_cycle(input bit av, input logic [2:0] op, input logic [3:0] sz,
                             input logic [31:0] addr, input logic [3:0] mask,
                             input logic [31:0] data, input logic src, input bit dr);
    bit acc;
    @(negedge clk);
    check_outputs();
    bus.a_valid = av; bus.a_opcode = op; bus.a_param = 0; bus.a_size = sz;
    bus.a_source = src; bus.a_address = addr; bus.a_mask = mask; bus.a_data = data;
    bus.d_ready = dr;
    #1;
    chk("a_ready", bus.a_ready, !exp_valid || dr);
    acc = av && (!exp_valid || dr);
    if (acc) model_accept(op, sz, addr, mask, data, src);
    else if (dr) exp_valid = 0;
  endtask

  task automatic pin(input string name, input logic [63:0] act, input logic [63:0] req);
    chk(name, act, req);
  endtask

  initial begin
    logic [2:0] op; logic [3:0] sz, m; logic [31:0] addr; int r;
    bus.a_valid = 0; bus.a_opcode = 0; bus.a_param = 0; bus.a_size = 0; bus.a_source = 0;
    bus.a_address = 0; bus.a_mask = 0; bus.a_data = 0; bus.d_ready = 1;
    model_reset();
    #3;
    pin("rst_d_valid", bus.d_valid, 0);
    pin("rst_d_data", bus.d_data, 0);
    pin("rst_d_opcode", bus.d_opcode, 0);
    pin("rst_a_ready", bus.a_ready, 1);
    #22 rst_n = 1'b1;

    for (int w = 0; w < DEPTH; w++)
      drive_cycle(1, 3'd0, 4'd2, w*4, 4'hF, 32'h1000_0000 + w, 0, 1);

    drive_cycle(1, 3'd0, 4'd2, 32'h10, 4'hF, 32'hDEADBEEF, 1, 1);
    @(posedge clk); #1;
    pin("putfull_opcode", bus.d_opcode, 0);
    pin("putfull_error", bus.d_error, 0);
    drive_cycle(1, 3'd4, 4'd2, 32'h10, 4'hF, 0, 1, 1);
    @(posedge clk); #1;
    pin("get_data", bus.d_data, 32'hDEADBEEF);
    pin("get_opcode", bus.d_opcode, 1);
    pin("get_size", bus.d_size, 2);
    pin("get_source", bus.d_source, 1);
    drive_cycle(1, 3'd1, 4'd2, 32'h10, 4'b0010, 32'h0000AA00, 0, 1);
    drive_cycle(1, 3'd4, 4'd2, 32'h10, 4'hF, 0, 0, 1);
    @(posedge clk); #1;
    pin("partial_data", bus.d_data, 32'hDEADAAEF);

    drive_cycle(1, 3'd4, 4'd2, 32'h0, 4'hF, 0, 0, 1);
    @(posedge clk); #1;
    pin("b2b_first", bus.d_data, 32'h1000_0000);
    drive_cycle(1, 3'd4, 4'd2, 32'h4, 4'hF, 0, 1, 1);
    @(posedge clk); #1;
    pin("b2b_second", bus.d_data, 32'h1000_0001);
    pin("b2b_valid", bus.d_valid, 1);

    drive_cycle(1, 3'd4, 4'd2, 32'h8, 4'hF, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1, 3'd4, 4'd2, 32'hC, 4'hF, 0, 1, 0);
      pin("bp_a_ready", bus.a_ready, 0);
      pin("bp_hold_data", bus.d_data, 32'h1000_0002);
    end
    drive_cycle(1, 3'd4, 4'd2, 32'hC, 4'hF, 0, 1, 1);
    pin("bp_release_ready", bus.a_ready, 1);
    @(posedge clk); #1;
    pin("bp_next_data", bus.d_data, 32'h1000_0003);

    drive_cycle(1, 3'd4, 4'd2, BASE + DEPTH*W, 4'hF, 0, 0, 1);
    @(posedge clk); #1;
    pin("err_range", bus.d_error, 1);
    pin("err_range_data", bus.d_data, 0);
    drive_cycle(1, 3'd4, 4'd2, 32'h2, 4'hF, 0, 0, 1);
    @(posedge clk); #1;
    pin("err_misalign", bus.d_error, 1);
    drive_cycle(1, 3'd3, 4'd2, 32'h0, 4'hF, 0, 0, 1);
    @(posedge clk); #1;
    pin("err_opcode", bus.d_error, 1);
    pin("err_opcode_ack", bus.d_opcode, 0);
    drive_cycle(1, 3'd0, 4'd2, 32'h0, 4'h3, 32'hFFFF_FFFF, 0, 1);
    @(posedge clk); #1;
    pin("err_mask", bus.d_error, 1);
    drive_cycle(1, 3'd4, 4'd2, 32'h0, 4'hF, 0, 0, 1);
    @(posedge clk); #1;
    pin("err_mask_nowrite", bus.d_data, 32'h1000_0000);

    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3 || r == 9) op = 3'd4;
      else if (r <= 5)      op = 3'd0;
      else if (r <= 7)      op = 3'd1;
      else begin
        op = 3'($urandom_range(2, 7));
        if (op == 3'd4) op = 3'd6;
      end
      sz = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) addr = 32'($urandom_range(0, 32'h1FF));
      else addr = BASE + 32'($urandom_range(0, DEPTH-1)) * W
                  + ((sz <= 2) ? ((32'($urandom_range(0, W-1)) >> sz) << sz) : 32'd0);
      m = 4'($urandom);
      if (op == 3'd0 && sz <= 2 && $urandom_range(0, 9) != 0) begin
        m = 0;
        for (int b = 0; b < W; b++)
          if (b >= (addr % W) && b < (addr % W) + (1 << sz)) m[b] = 1'b1;
      end
      drive_cycle($urandom_range(0, 4) != 0, op, sz, addr, m, $urandom, 1'($urandom),
                  $urandom_range(0, 9) < 7);
    end

    drive_cycle(1, 3'd4, 4'd2, 32'h10, 4'hF, 0, 1, 0);
    drive_cycle(0, 3'd4, 4'd2, 32'h10, 4'hF, 0, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    pin("mid_rst_d_valid", bus.d_valid, 0);
    pin("mid_rst_d_data", bus.d_data, 0);
    pin("mid_rst_d_size", bus.d_size, 0);
    pin("mid_rst_d_source", bus.d_source, 0);
    pin("mid_rst_d_error", bus.d_error, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    pin("post_rst_a_ready", bus.a_ready, 1);
    drive_cycle(1, 3'd4, 4'd2, 32'h10, 4'hF, 0, 0, 1);
    drive_cycle(0, 3'd4, 4'd2, 32'h10, 4'hF, 0, 0, 1);
    drive_cycle(0, 3'd4, 4'd2, 32'h10, 4'hF, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
